f2d_pipe_ctrl: RTL and testbench

- Stall/flush sequencer for the fetch-to-decode pipeline register and the PC register.
- Takes hazard, redirect, memory-busy and halt indications from the F, D, X and M stages.
- Produces the write enables and bubble-insert controls for the PC, the F/D latch and the D/X latch.
- Sits beside the F/D latch in the pipeline top level. Holds a small FSM and a branch-penalty counter.

---
 rtl/f2d_pipe_ctrl_pkg.sv | 18 +
 rtl/f2d_sat_counter.sv | 24 ++
 rtl/f2d_pipe_ctrl.sv | 162 ++++++++++++++++
 tb/tb_f2d_pipe_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/f2d_pipe_ctrl_pkg.sv
// Shared definitions for the fetch-to-decode stall/flush sequencer and the
// F/D and D/X pipeline latches.
package f2d_pipe_ctrl_pkg;

  // Sequencer state encoding (2 bits)
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FLUSH = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  // Width of the branch-penalty counter (penalty range 0..7)
  localparam int unsigned PEN_W = 3;

  // Instruction word the latches load when a bubble is inserted (addi x0,x0,0)
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : f2d_pipe_ctrl_pkg

// File: rtl/f2d_sat_counter.sv
// Saturating up-counter used for the optional stall/flush performance counts.
module f2d_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Count up on inc, holding at all-ones once reached
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule : f2d_sat_counter

// File: rtl/f2d_pipe_ctrl.sv
// Stall/flush sequencer for the PC register, F/D latch and D/X latch.
// Optional performance counters are built when F2D_PERF_CNT_EN is defined.
module f2d_pipe_ctrl
  import f2d_pipe_ctrl_pkg::*;
#(
  parameter int unsigned BR_PENALTY = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             loadUseHazD,
  input  logic             branchTakenX,
  input  logic             imemStallF,
  input  logic             dmemStallM,
  input  logic             haltD,
  input  logic             instrValidD,
  output logic             pcWrEn,
  output logic             f2dWrEn,
  output logic             f2dBubble,
  output logic             d2xBubble,
  output logic             halted,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt
);

  localparam logic [PEN_W-1:0] PEN_RELOAD = PEN_W'(BR_PENALTY);
  localparam logic             PEN_EN     = (BR_PENALTY != 0);

  state_t           r_state;
  state_t           w_next_state;
  logic [PEN_W-1:0] r_pen_cnt;
  logic [PEN_W-1:0] w_next_pen;
  logic             w_pc_wr;
  logic             w_f2d_wr;
  logic             w_f2d_bub;
  logic             w_d2x_bub;
  logic             w_halted;

  // State and penalty-counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_RUN;
      r_pen_cnt <= '0;
    end else begin
      r_state   <= w_next_state;
      r_pen_cnt <= w_next_pen;
    end
  end

  // Next-state and combinational pipeline controls; reset forces NOP fill
  always_comb begin
    w_next_state = r_state;
    w_next_pen   = r_pen_cnt;
    w_pc_wr      = 1'b0;
    w_f2d_wr     = 1'b0;
    w_f2d_bub    = 1'b0;
    w_d2x_bub    = 1'b0;
    w_halted     = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (dmemStallM) begin
          // whole pipe frozen
        end else if (branchTakenX) begin
          w_pc_wr   = 1'b1;
          w_f2d_wr  = 1'b1;
          w_f2d_bub = 1'b1;
          w_d2x_bub = 1'b1;
          if (PEN_EN) begin
            w_next_state = ST_FLUSH;
            w_next_pen   = PEN_RELOAD;
          end
        end else if (haltD && instrValidD) begin
          w_f2d_wr     = 1'b1;
          w_f2d_bub    = 1'b1;
          w_next_state = ST_HALT;
        end else if (loadUseHazD) begin
          w_d2x_bub = 1'b1;
        end else if (imemStallF) begin
          w_f2d_wr  = 1'b1;
          w_f2d_bub = 1'b1;
        end else begin
          w_pc_wr  = 1'b1;
          w_f2d_wr = 1'b1;
        end
      end

      ST_FLUSH: begin
        if (dmemStallM) begin
          // frozen; penalty count holds
        end else if (branchTakenX) begin
          w_pc_wr    = 1'b1;
          w_f2d_wr   = 1'b1;
          w_f2d_bub  = 1'b1;
          w_d2x_bub  = 1'b1;
          w_next_pen = PEN_RELOAD;
        end else begin
          // wrong-path slots: hazards, halts and imem stalls are ignored
          w_pc_wr    = 1'b1;
          w_f2d_wr   = 1'b1;
          w_f2d_bub  = 1'b1;
          w_next_pen = r_pen_cnt - PEN_W'(1);
          if (r_pen_cnt == PEN_W'(1)) begin
            w_next_state = ST_RUN;
          end
        end
      end

      ST_HALT: begin
        w_f2d_wr  = 1'b1;
        w_f2d_bub = 1'b1;
        w_halted  = 1'b1;
      end

      default: begin
        w_next_state = ST_RUN;
        w_next_pen   = '0;
      end
    endcase

    if (!rst) begin
      w_pc_wr   = 1'b0;
      w_f2d_wr  = 1'b1;
      w_f2d_bub = 1'b1;
      w_d2x_bub = 1'b1;
      w_halted  = 1'b0;
    end
  end

  assign pcWrEn    = w_pc_wr;
  assign f2dWrEn   = w_f2d_wr;
  assign f2dBubble = w_f2d_bub;
  assign d2xBubble = w_d2x_bub;
  assign halted    = w_halted;

`ifdef F2D_PERF_CNT_EN
  logic w_stall_inc;
  logic w_flush_inc;

  // Stall cycles exclude the halted state; flushed slots are bubbled F/D loads
  assign w_stall_inc = rst & ~w_pc_wr & (r_state != ST_HALT);
  assign w_flush_inc = rst & w_f2d_bub;

  f2d_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_stall_inc),
    .cnt (stallCnt)
  );

  f2d_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_flush_inc),
    .cnt (flushCnt)
  );
`else
  assign stallCnt = '0;
  assign flushCnt = '0;
`endif

endmodule : f2d_pipe_ctrl

// File: tb/tb_f2d_pipe_ctrl.sv
// Self-checking bench for f2d_pipe_ctrl: directed test-plan sequences followed
// by randomized traffic, compared against a cycle-level behavioural model.
module tb_f2d_pipe_ctrl;

  localparam int unsigned P  = 2;
  localparam int unsigned CW = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic loadUseHazD, branchTakenX, imemStallF, dmemStallM, haltD, instrValidD;
  logic pcWrEn, f2dWrEn, f2dBubble, d2xBubble, halted;
  logic [CW-1:0] stallCnt, flushCnt;

  always #5 clk = ~clk;

  f2d_pipe_ctrl #(.BR_PENALTY(P), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .loadUseHazD  (loadUseHazD),
    .branchTakenX (branchTakenX),
    .imemStallF   (imemStallF),
    .dmemStallM   (dmemStallM),
    .haltD        (haltD),
    .instrValidD  (instrValidD),
    .pcWrEn       (pcWrEn),
    .f2dWrEn      (f2dWrEn),
    .f2dBubble    (f2dBubble),
    .d2xBubble    (d2xBubble),
    .halted       (halted),
    .stallCnt     (stallCnt),
    .flushCnt     (flushCnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: bubbles still owed after a branch, halt flag, counts
  int       m_rem;
  bit       m_halt;
  int       m_stall;
  int       m_flush;
  logic [4:0] exp_ctl;   // {pcWrEn, f2dWrEn, f2dBubble, d2xBubble, halted}
  int       nxt_rem;
  bit       nxt_halt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_rem   = 0;
    m_halt  = 0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // Expected controls for the current inputs, plus the model's next state
  function automatic void model_eval();
    nxt_rem  = m_rem;
    nxt_halt = m_halt;
    if (!rst)                       exp_ctl = 5'b01110;
    else if (m_halt)                exp_ctl = 5'b01101;
    else if (dmemStallM)            exp_ctl = 5'b00000;
    else if (branchTakenX) begin
      exp_ctl = 5'b11110;
      nxt_rem = P;
    end else if (m_rem > 0) begin
      exp_ctl = 5'b11100;
      nxt_rem = m_rem - 1;
    end else if (haltD && instrValidD) begin
      exp_ctl  = 5'b01100;
      nxt_halt = 1;
    end else if (loadUseHazD)       exp_ctl = 5'b00010;
    else if (imemStallF)            exp_ctl = 5'b01100;
    else                            exp_ctl = 5'b11000;
  endfunction

  task automatic check_now(input string tag);
    model_eval();
    chk({tag, ".ctl"}, 32'({pcWrEn, f2dWrEn, f2dBubble, d2xBubble, halted}), 32'(exp_ctl));
`ifdef F2D_PERF_CNT_EN
    chk({tag, ".stall"}, 32'(stallCnt), 32'(m_stall));
    chk({tag, ".flush"}, 32'(flushCnt), 32'(m_flush));
`else
    chk({tag, ".cnt"}, 32'({stallCnt, flushCnt}), 32'd0);
`endif
  endtask

  // Advance the model across a rising edge using the last evaluated controls
  task automatic model_clock();
    if (!rst) begin
      model_reset();
    end else begin
      if (!exp_ctl[4] && !m_halt && m_stall < CNT_MAX) m_stall++;
      if (exp_ctl[2] && m_flush < CNT_MAX)             m_flush++;
      m_rem  = nxt_rem;
      m_halt = nxt_halt;
    end
  endtask

  // One clock cycle: v = {rst, loadUse, branch, imem, dmem, halt, valid}
  task automatic cycle(input string tag, input logic [6:0] v);
    @(negedge clk);
    {rst, loadUseHazD, branchTakenX, imemStallF, dmemStallM, haltD, instrValidD} = v;
    #1;
    check_now(tag);
    @(posedge clk);
    model_clock();
  endtask

  localparam logic [6:0] IDLE = 7'b1000000;
  localparam logic [6:0] RSTV = 7'b0000000;
  localparam logic [6:0] LU   = 7'b1100000;
  localparam logic [6:0] BR   = 7'b1010000;
  localparam logic [6:0] DM   = 7'b1000100;
  localparam logic [6:0] HLT  = 7'b1000011;
  localparam logic [6:0] BRH  = 7'b1010011;

  initial begin
    rst = 1'b0;
    {loadUseHazD, branchTakenX, imemStallF, dmemStallM, haltD, instrValidD} = '0;
    model_reset();

    // reset state
    cycle("reset0", RSTV);
    cycle("reset1", RSTV);

    // clean run
    for (int i = 0; i < 3; i++) cycle("clean", IDLE);

    // load-use stall for one cycle
    cycle("loaduse", LU);
    cycle("lu_after", IDLE);

    // taken branch: three bubbled F/D slots, then normal
    cycle("br", BR);
    for (int i = 0; i < 3; i++) cycle("br_tail", IDLE);

    // data-memory freeze in the middle of the flush
    cycle("br2", BR);
    cycle("flush_dm0", DM);
    cycle("flush_dm1", DM);
    for (int i = 0; i < 3; i++) cycle("flush_resume", IDLE);

    // branch beats halt, then a lone halt sticks until reset
    cycle("br_halt", BRH);
    cycle("flush_a", IDLE);
    cycle("flush_b", IDLE);
    cycle("halt", HLT);
    for (int i = 0; i < 10; i++) cycle("halted", IDLE);
    cycle("halted_br", BR);

    // asynchronous reset between clock edges during a flush
    cycle("rst_pre", RSTV);
    cycle("run_pre", IDLE);
    cycle("br3", BR);
    @(negedge clk);
    {rst, loadUseHazD, branchTakenX, imemStallF, dmemStallM, haltD, instrValidD} = IDLE;
    #1;
    check_now("mid_flush");
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_now("async_rst");
    @(posedge clk);
    model_clock();
    cycle("rst_hold", RSTV);
    cycle("rst_release", IDLE);
    cycle("run_after", IDLE);

    // randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      logic [6:0] v;
      v[6] = ($urandom_range(0, 59) != 0);
      v[5] = ($urandom_range(0, 3) == 0);
      v[4] = ($urandom_range(0, 5) == 0);
      v[3] = ($urandom_range(0, 4) == 0);
      v[2] = ($urandom_range(0, 5) == 0);
      v[1] = ($urandom_range(0, 24) == 0);
      v[0] = 1'($urandom_range(0, 1));
      cycle("rand", v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_f2d_pipe_ctrl
